// File: rtl/uart_pkg.sv
// Shared UART definitions: message sequencer state encoding and the default
// character width used by the UART test blocks.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    GAP,
    ECHO_SEND,
    ECHO_WAIT
  } msg_state_t;

endpackage

// File: rtl/uart_msg_seq.sv
// Message sequencer for UART bring-up: streams a fixed message into a
// byte-level transmitter, optionally repeating it with an idle gap, and
// optionally echoing a received byte between messages.
module uart_msg_seq
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int MAX_LEN = 16,
  parameter logic [MAX_LEN*DATA_WIDTH-1:0] MSG = (MAX_LEN*DATA_WIDTH)'(40'h4F_4C_4C_45_48),
  parameter int GAP_CYCLES = 0,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  go,
  input  logic [LW-1:0]         msg_len,
  input  logic                  repeat_en,
  input  logic                  echo_en,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_done,
  output logic                  busy,
  output logic                  msg_done,
  output logic                  overrun
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LW-1:0] MAX_LEN_W = LW'(MAX_LEN);
  localparam msg_state_t REPEAT_STATE = (GAP_CYCLES == 0) ? SEND : GAP;

  msg_state_t state, next_state;
  logic [LW-1:0] index, next_index, len, eff_len;
  logic [GW-1:0] gap_cnt;
  logic [DATA_WIDTH-1:0] echo_reg;
  logic echo_full, resume;
  logic accept_go, last_done, last_char, echo_take, echo_drop;

  function automatic logic [DATA_WIDTH-1:0] msg_char(input logic [LW-1:0] i);
    msg_char = MSG[int'(i)*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  assign eff_len   = (msg_len > MAX_LEN_W) ? MAX_LEN_W : msg_len;
  assign last_char = (index == len - LW'(1));
  // The echo register can accept a new byte in the same cycle it hands its old one to the transmitter.
  assign echo_take = rx_valid && echo_en && (!echo_full || state == ECHO_SEND);
  assign echo_drop = rx_valid && echo_en && echo_full && (state != ECHO_SEND);

  // Next-state decode: echo has priority in IDLE, go is only honoured in IDLE.
  always_comb begin
    next_state = state;
    next_index = index;
    accept_go  = 1'b0;
    last_done  = 1'b0;
    case (state)
      IDLE: begin
        if (echo_full) begin
          next_state = ECHO_SEND;
        end else if (go && eff_len != '0) begin
          next_state = SEND;
          next_index = '0;
          accept_go  = 1'b1;
        end
      end
      SEND: next_state = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (!last_char) begin
            next_index = index + LW'(1);
            next_state = SEND;
          end else begin
            last_done  = 1'b1;
            next_index = '0;
            if (echo_full)      next_state = ECHO_SEND;
            else if (repeat_en) next_state = REPEAT_STATE;
            else                next_state = IDLE;
          end
        end
      end
      GAP: begin
        if (!repeat_en)              next_state = IDLE;
        else if (gap_cnt == GAP_LAST) next_state = SEND;
      end
      ECHO_SEND: next_state = ECHO_WAIT;
      ECHO_WAIT: begin
        if (tx_done) next_state = (resume && repeat_en) ? REPEAT_STATE : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State, character index, latched length, gap counter and repeat-resume flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      index   <= '0;
      len     <= '0;
      gap_cnt <= '0;
      resume  <= 1'b0;
    end else begin
      state   <= next_state;
      index   <= next_index;
      gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;
      if (accept_go) len <= eff_len;
      if (last_done)          resume <= repeat_en;
      else if (state == IDLE) resume <= 1'b0;
    end
  end

  // Single-entry echo holding register; empties when its byte is launched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      echo_reg  <= '0;
      echo_full <= 1'b0;
    end else begin
      if (state == ECHO_SEND) echo_full <= 1'b0;
      if (echo_take) begin
        echo_reg  <= rx_data;
        echo_full <= 1'b1;
      end
    end
  end

  // Registered outputs derived from the upcoming state so they align with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_start <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      msg_done <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      tx_start <= (next_state == SEND) || (next_state == ECHO_SEND);
      if (next_state == SEND)           tx_data <= msg_char(next_index);
      else if (next_state == ECHO_SEND) tx_data <= echo_reg;
      busy     <= (next_state != IDLE);
      msg_done <= last_done;
      overrun  <= echo_drop;
    end
  end

endmodule
